// File: rtl/opn_reg_writer.sv
// rtl/opn_reg_writer.sv - OPN bus-write sequencer with pair FIFO
//
// opn_pair_fifo: first-word-fall-through FIFO holding {reg, val} pairs.
//   clk_in, rst      clock, async active-high reset
//   push, push_data  write one entry (caller guarantees !full)
//   pop, head        drop the head entry (caller guarantees !empty); head is the oldest entry
//   full, empty      occupancy flags
//   level            entries held
//
// opn_reg_writer: buffers (register, value) pairs and replays each as the two-phase
// OPN bus write (address phase on addr=0, data phase on addr=1), timing strobe
// width and gaps so sources never hand-time bus cycles.
//   clk_in           core clock
//   rst              async active-high reset
//   cen              clock enable; the sequencer advances only when 1
//   wr_valid/ready   pair handshake; wr_ready = FIFO not full (push ignores cen)
//   wr_reg, wr_val   OPN register address and value
//   bus_din          to top.din
//   bus_addr         to top.addr (0 address phase, 1 data phase)
//   bus_cs_n         to top.cs_n
//   bus_wr_n         to top.wr_n
//   busy             sequencer not idle
//   done             one-clock pulse when a pair's post-write gap completes
//   fifo_level       entries held

module opn_pair_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
endmodule

module opn_reg_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int WR_PULSE   = 1,
  parameter int ADDR_GAP   = 1,
  parameter int DATA_GAP   = 16
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          cen,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [7:0]                    wr_reg,
  input  logic [7:0]                    wr_val,
  output logic [7:0]                    bus_din,
  output logic                          bus_addr,
  output logic                          bus_cs_n,
  output logic                          bus_wr_n,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_WR  = 3'd2,
    A_GAP = 3'd3,
    D_SET = 3'd4,
    D_WR  = 3'd5,
    D_GAP = 3'd6
  } state_t;

  // Counters load N-1 on state entry and the state exits when the count is zero.
  localparam logic [15:0] PULSE_LD = 16'(WR_PULSE - 1);
  localparam logic [15:0] AGAP_LD  = 16'(ADDR_GAP - 1);
  localparam logic [15:0] DGAP_LD  = 16'(DATA_GAP - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  pair_val;
  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_head;
  logic        push, pop;
  logic        finish;
  logic        cnt_zero;

  assign wr_ready = !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign cnt_zero = (cnt == 16'd0);

  opn_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst       (rst),
    .push      (push),
    .push_data ({wr_reg, wr_val}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    finish  = 1'b0;
    if (cen) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state_n = A_SET;
            pop     = 1'b1;
          end
        end
        A_SET: begin
          state_n = A_WR;
          cnt_n   = PULSE_LD;
        end
        A_WR: begin
          if (!cnt_zero) begin
            cnt_n = cnt - 16'd1;
          end else if (ADDR_GAP == 0) begin
            state_n = D_SET;
          end else begin
            state_n = A_GAP;
            cnt_n   = AGAP_LD;
          end
        end
        A_GAP: begin
          if (!cnt_zero) cnt_n = cnt - 16'd1;
          else           state_n = D_SET;
        end
        D_SET: begin
          state_n = D_WR;
          cnt_n   = PULSE_LD;
        end
        D_WR: begin
          if (!cnt_zero) begin
            cnt_n = cnt - 16'd1;
          end else if (DATA_GAP == 0) begin
            finish = 1'b1;
          end else begin
            state_n = D_GAP;
            cnt_n   = DGAP_LD;
          end
        end
        D_GAP: begin
          if (!cnt_zero) cnt_n = cnt - 16'd1;
          else           finish = 1'b1;
        end
        default: state_n = IDLE;
      endcase

      // Back-to-back pairs go straight to A_SET with no idle cycle in between.
      if (finish) begin
        if (!fifo_empty) begin
          state_n = A_SET;
          pop     = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      pair_val <= 8'd0;
      bus_din  <= 8'd0;
      bus_addr <= 1'b0;
      bus_cs_n <= 1'b1;
      bus_wr_n <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // done is cleared on every clock so it stays one clock wide even when cen is sparse.
      done <= finish;
      if (cen) begin
        state    <= state_n;
        cnt      <= cnt_n;
        bus_cs_n <= (state_n == IDLE);
        bus_wr_n <= !((state_n == A_WR) || (state_n == D_WR));
        bus_addr <= (state_n == D_SET) || (state_n == D_WR) || (state_n == D_GAP);
        busy     <= (state_n != IDLE);
        // din changes only at A_SET/D_SET, giving a full setup cycle before each strobe.
        if (pop) begin
          bus_din  <= fifo_head[15:8];
          pair_val <= fifo_head[7:0];
        end else if (state_n == D_SET) begin
          bus_din  <= pair_val;
        end
      end
    end
  end
endmodule
